walk_mem_responder: RTL
=======================

Name: walk_mem_responder

Overview:
- Responder end of the table-walk/MMU memory read interface.
- Accepts read and write requests, carrying an address and an access size, from an initiator such as the table walker.
- Serves them from an internal word-organised backing store that emulates DRAM with a fixed access latency.
- Returns data or an error on a four-phase request/valid handshake, so initiators never have to poll for non-zero data.

Parameters:
- ADDR_W, 14, byte address width (matches the MMU physical/virtual address width).
- DEPTH_WORDS, 4096, number of 32-bit words in the backing store (covers 2^ADDR_W bytes).
- LATENCY, 4, cycles from request acceptance to response (legal 1..15).

Ports:
- in_clk  input  1  Clock. Everything is on its rising edge.
- in_rst_n  input  1  Asynchronous, active-low reset.
- in_ren  input  1  Read request. Held high by the initiator until out_valid is seen.
- in_wen  input  1  Write request. Same handshake as in_ren.
- in_addr  input  ADDR_W  Byte address.
- in_size  input  2  Access size: 00 byte, 01 halfword, 10 word, 11 illegal.
- in_wdata  input  32  Write data, right-aligned (byte in [7:0], halfword in [15:0]).
- out_data  output  32  Read data, zero-extended and right-aligned. Returns 0 for writes and errors.
- out_valid  output  1  Response valid. Held while the request remains high.
- out_err  output  1  Response is an error. Qualified by out_valid.
- out_busy  output  1  High in every state other than IDLE.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - State returns to IDLE and the latency counter clears.
  - out_data=0, out_valid=0, out_err=0, out_busy=0.
  - A request in flight is discarded; a pending write does not modify memory.
  - Backing store contents are not reset.
- States: IDLE, WAIT, RESP, DRAIN.
- IDLE: a request (in_ren | in_wen) is accepted on the edge where it is first sampled high. On that edge:
  - addr, size, wdata and op are captured. Later input changes are ignored until the next acceptance.
  - Error check: an error is flagged if in_ren & in_wen, in_size==11, a halfword with addr[0]=1, or a word with addr[1:0]!=00.
  - Error path: go to RESP directly. out_valid=1, out_err=1, out_data=0 on the next edge, i.e. 1-cycle latency. Memory is untouched.
  - Otherwise: load the counter with LATENCY-1 and go to WAIT, or straight to RESP if LATENCY==1.
- WAIT: decrement the counter each cycle. When it reaches 0, perform the access and go to RESP.
  - out_valid rises exactly LATENCY edges after the accepting edge.
- Access rules:
  - Word index = addr[ADDR_W-1:2].
  - Little-endian lane select: byte lane addr[1:0], halfword lane addr[1].
  - Writes update only the selected lanes.
  - Reads extract the selected lane into out_data[7:0] or [15:0], with the upper bits 0.
- RESP: out_valid=1 (and out_err if flagged) with out_data stable.
  - Stay in RESP while the request (in_ren | in_wen) remains high.
  - When the request is sampled low, clear out_valid, out_err and out_data on that edge and return to IDLE.
  - A new request is accepted no earlier than the following edge, so there is a minimum of one idle cycle between transactions.
- DRAIN: reserved encoding. Any unreachable state recovers to IDLE with outputs cleared.
- Request dropped during WAIT (protocol violation): the access still completes. RESP is entered, then it exits to IDLE on the next edge because the request is low, leaving a 1-cycle out_valid pulse.
- Only one transaction is outstanding at a time. No pipelining.
- Address bits above the DEPTH_WORDS range wrap modulo DEPTH_WORDS.

Test Plan:
- Word write/read latency: write addr 0x0040 = 0xDEADBEEF (size 10), then read the same address.
  - out_valid rises exactly 4 edges after acceptance; out_data=0xDEADBEEF; out_err=0.
- Byte and halfword lanes: starting from 0xDEADBEEF at 0x0040, write byte 0x11 to 0x0042 and halfword 0x2233 to 0x0040.
  - Word read returns 0xDE112233.
  - Byte read of 0x0043 returns 0x000000DE.
  - Halfword read of 0x0042 returns 0x0000DE11.
- Errors, all responding 1 cycle after acceptance with out_valid=1, out_err=1, out_data=0 and the memory word unchanged on a subsequent read:
  - word read at 0x0041;
  - halfword read at 0x0003;
  - size 11;
  - in_ren & in_wen together.
- Handshake: hold in_ren high for 10 cycles after out_valid.
  - out_valid and out_data stay stable throughout.
  - After in_ren falls, out_valid clears on the next edge.
  - A re-raised in_ren is accepted only after IDLE is reached, and exactly one response is produced per request.
- Reset mid-operation:
  - Assert in_rst_n low asynchronously in WAIT of a write to 0x0080 (word previously 0x12345678). All outputs go to 0 immediately, and a later read returns 0x12345678.
  - A reset during RESP clears out_valid without a clock edge.
- Three-level walk sequence:
  - Preload 0x0000=0x00000440, 0x0110=0x00000880, and 0x0220=0x000003A0.
  - Issue back-to-back word reads of 0x0000, 0x0110 and 0x0220.
  - The three responses are returned in order, each LATENCY edges after its acceptance, with no stale data between them.

Source files
------------

// File: rtl/walk_mem_if.sv
// Request/response bundle between a table-walk initiator and its memory responder.
// in_* travel initiator -> responder, out_* travel responder -> initiator.
interface walk_mem_if #(
    parameter int ADDR_W = 14
) ();
    logic              in_ren;
    logic              in_wen;
    logic [ADDR_W-1:0] in_addr;
    logic [1:0]        in_size;
    logic [31:0]       in_wdata;
    logic [31:0]       out_data;
    logic              out_valid;
    logic              out_err;
    logic              out_busy;

    // Four-phase handshake: the initiator raises in_ren or in_wen and holds it
    // (with addr/size/wdata) until out_valid is seen; the responder holds
    // out_valid/out_err/out_data stable while the request stays high, and drops
    // them on the edge where the request is sampled low.
    modport master (
        output in_ren, in_wen, in_addr, in_size, in_wdata,
        input  out_data, out_valid, out_err, out_busy
    );

    modport slave (
        input  in_ren, in_wen, in_addr, in_size, in_wdata,
        output out_data, out_valid, out_err, out_busy
    );
endinterface

// File: rtl/walk_mem_responder.sv
// Fixed-latency DRAM stand-in for the table walker: one outstanding byte/halfword/word
// access at a time, answered over the walk_mem_if four-phase handshake.
module walk_mem_responder #(
    parameter int ADDR_W      = 14,
    parameter int DEPTH_WORDS = 4096,
    parameter int LATENCY     = 4
) (
    input  logic       in_clk,
    input  logic       in_rst_n,
    walk_mem_if.slave  bus,
    output logic [1:0] dbg_state
);
    localparam int         IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_RESP  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [31:0]       data_q, data_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;

    logic              req, req_err, acc_go, acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [1:0]        acc_size;
    logic [31:0]       acc_wdata;
    logic [IDX_W-1:0]  acc_idx;
    logic [31:0]       mem_word, rd_lane, wr_word;

    logic [31:0] mem [DEPTH_WORDS];

    assign req     = bus.in_ren | bus.in_wen;
    assign req_err = (bus.in_ren & bus.in_wen) | (bus.in_size == 2'b11)
                   | ((bus.in_size == 2'b01) & bus.in_addr[0])
                   | ((bus.in_size == 2'b10) & (bus.in_addr[1:0] != 2'b00));

    // With LATENCY==1 the access happens on the accepting edge, so IDLE uses live inputs.
    assign acc_addr  = (state_q == S_IDLE) ? bus.in_addr  : addr_q;
    assign acc_size  = (state_q == S_IDLE) ? bus.in_size  : size_q;
    assign acc_wdata = (state_q == S_IDLE) ? bus.in_wdata : wdata_q;
    assign acc_we    = (state_q == S_IDLE) ? bus.in_wen   : we_q;
    assign acc_idx   = IDX_W'(32'(acc_addr[ADDR_W-1:2]) % 32'(DEPTH_WORDS));
    assign mem_word  = mem[acc_idx];

    always_comb begin
        rd_lane = mem_word;
        wr_word = mem_word;
        case (acc_size)
            2'b00: begin
                rd_lane = {24'd0, mem_word[{acc_addr[1:0], 3'b000} +: 8]};
                wr_word[{acc_addr[1:0], 3'b000} +: 8] = acc_wdata[7:0];
            end
            2'b01: begin
                rd_lane = {16'd0, mem_word[{acc_addr[1], 4'b0000} +: 16]};
                wr_word[{acc_addr[1], 4'b0000} +: 16] = acc_wdata[15:0];
            end
            default: wr_word = acc_wdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        size_d  = size_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        data_d  = data_q;
        valid_d = valid_q;
        err_d   = err_q;
        acc_go  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d  = bus.in_addr;
                    size_d  = bus.in_size;
                    wdata_d = bus.in_wdata;
                    we_d    = bus.in_wen;
                    if (req_err) begin
                        state_d = S_RESP;
                        valid_d = 1'b1;
                        err_d   = 1'b1;
                        data_d  = 32'd0;
                    end else if (LATENCY == 1) begin
                        acc_go  = 1'b1;
                        state_d = S_RESP;
                        valid_d = 1'b1;
                        err_d   = 1'b0;
                        data_d  = bus.in_wen ? 32'd0 : rd_lane;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                // The access lands on the edge where the counter reaches zero.
                if (cnt_q <= 4'd1) begin
                    acc_go  = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = S_RESP;
                    valid_d = 1'b1;
                    err_d   = 1'b0;
                    data_d  = we_q ? 32'd0 : rd_lane;
                end
            end
            S_RESP: begin
                if (!req) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    err_d   = 1'b0;
                    data_d  = 32'd0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
                valid_d = 1'b0;
                err_d   = 1'b0;
                data_d  = 32'd0;
            end
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            size_q  <= 2'b00;
            wdata_q <= 32'd0;
            we_q    <= 1'b0;
            data_q  <= 32'd0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // Backing store is never reset; a write held off by reset must not land.
    always_ff @(posedge in_clk) begin
        if (acc_go && acc_we && in_rst_n) begin
            mem[acc_idx] <= wr_word;
        end
    end

    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;
    assign bus.out_err   = err_q;
    assign bus.out_busy  = (state_q != S_IDLE);
    assign dbg_state     = state_q;
endmodule
